// File: rtl/stack_pkg.sv
// Shared definitions for the stack machine: opcode encodings, the program
// memory phase enum and the OP_NUL filler word used for out-of-range reads.
package stack_pkg;

    localparam logic [7:0] OP_ADD   = 8'd0;
    localparam logic [7:0] OP_SUB   = 8'd1;
    localparam logic [7:0] OP_AND   = 8'd2;
    localparam logic [7:0] OP_OR    = 8'd3;
    localparam logic [7:0] OP_XOR   = 8'd4;
    localparam logic [7:0] OP_NOT   = 8'd5;
    localparam logic [7:0] OP_PUSH  = 8'd6;
    localparam logic [7:0] OP_POP   = 8'd7;
    localparam logic [7:0] OP_DUP   = 8'd8;
    localparam logic [7:0] OP_SWAP  = 8'd9;
    localparam logic [7:0] OP_LOAD  = 8'd10;
    localparam logic [7:0] OP_STORE = 8'd11;
    localparam logic [7:0] OP_JMP   = 8'd12;
    localparam logic [7:0] OP_JZ    = 8'd13;
    localparam logic [7:0] OP_OUT   = 8'd14;
    localparam logic [7:0] OP_NUL   = 8'd15;

    typedef enum logic {
        MS_LOAD,
        MS_RUN
    } mem_state_t;

    // OP_NUL zero-extended (or truncated for very narrow words) to the given width.
    function automatic logic [31:0] nul_word(input int width);
        logic [31:0] mask;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return {24'd0, OP_NUL} & mask;
    endfunction

endpackage

// File: rtl/sp_ram.sv
// Plain single-port synchronous RAM; a simultaneous read and write of the
// same word returns the data being written.
module sp_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= we ? wdata : mem[addr];
        end
    end

endmodule

// File: rtl/program_memory.sv
// Program/data memory for the stack machine: a byte-stream loader fills the
// RAM after reset, then the core gets one-cycle reads and range-checked writes.
module program_memory
    import stack_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic              reload,
    output logic              running,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              we,
    input  logic              re,
    output logic [DATA_W-1:0] data_out,
    output logic              addr_err
);

    localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DATA_W-1:0] NUL_WORD = DATA_W'(nul_word(DATA_W));
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    mem_state_t        state, state_next;
    logic [ADDR_W-1:0] ptr, ptr_next;
    logic              in_range, load_fire, core_active;
    logic              ram_we, ram_re;
    logic [RAM_AW-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;
    logic              out_zero, out_nul;

    assign load_ready  = (state == MS_LOAD) & ~rst;
    assign running     = (state == MS_RUN);
    assign in_range    = {1'b0, mem_addr} < DEPTH_X;
    assign load_fire   = load_valid & load_ready;
    assign core_active = (state == MS_RUN) & ~rst;

    // The loader owns the RAM port in LOAD; the core owns it in RUN, but only for in-range words.
    always_comb begin
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = ptr[RAM_AW-1:0];
        ram_wdata = load_data;
        if (load_fire) begin
            ram_we = 1'b1;
        end else if (core_active && in_range) begin
            ram_we    = we;
            ram_re    = re;
            ram_addr  = mem_addr[RAM_AW-1:0];
            ram_wdata = data_in;
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        case (state)
            MS_LOAD: begin
                if (load_valid) begin
                    ptr_next = ptr + 1'b1;
                    if (load_last || ptr == LAST_PTR) begin
                        state_next = MS_RUN;
                        ptr_next   = '0;
                    end
                end
            end
            MS_RUN: begin
                if (reload) begin
                    state_next = MS_LOAD;
                    ptr_next   = '0;
                end
            end
            default: state_next = MS_LOAD;
        endcase
    end

    // data_out is the RAM read register, overridden by zero after reset or OP_NUL after a bad read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= MS_LOAD;
            ptr      <= '0;
            addr_err <= 1'b0;
            out_zero <= 1'b1;
            out_nul  <= 1'b0;
        end else begin
            state    <= state_next;
            ptr      <= ptr_next;
            addr_err <= core_active & (we | re) & ~in_range;
            if (core_active && re) begin
                out_zero <= 1'b0;
                out_nul  <= ~in_range;
            end
        end
    end

    assign data_out = out_zero ? '0 : (out_nul ? NUL_WORD : ram_rdata);

    sp_ram #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(RAM_AW)
    ) ram (
        .clk  (clk),
        .we   (ram_we),
        .re   (ram_re),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

endmodule
